dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data-memory port between the pipelined CPU and an external requester (loader, debug or DMA agent). Sits between `riscv_cpu` and `data_mem` in the top level, muxing the address, write data, write enable and store width, and freezing the CPU with a stall while the external side owns the port. The CPU has priority; a starvation counter guarantees the external side is eventually served.

## Interface

**Parameters**
- `MAX_STARVE`, default 4: consecutive contended cycles after which the external requester wins.
- `SCNT_W`, default 3: starvation counter width; must satisfy 2^SCNT_W > MAX_STARVE.

**Ports**
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `cpu_req` input 1: CPU memory access this cycle (load or store in MEM stage).
- `cpu_we` input 1: CPU store.
- `cpu_store` input 3: CPU funct3 width code.
- `cpu_addr` input 32: CPU address.
- `cpu_wdata` input 32: CPU store data.
- `cpu_stall` output 1: freeze CPU pipeline.
- `ext_req` input 1: external request; held until `ext_ack`.
- `ext_we` input 1: external write (word only).
- `ext_addr` input 32: external byte address; must be word-aligned.
- `ext_wdata` input 32: external write data.
- `ext_ack` output 1: one-cycle completion pulse.
- `ext_err` output 1: valid with `ext_ack`; misaligned access.
- `ext_rdata` output 32: registered read data, valid with `ext_ack`.
- `MemWrite` output 1, `Store` output 3, `DataAdr` output 32, `WriteData` output 32: to `data_mem`.
- `ReadData` input 32: combinational read data from `data_mem`.
- `ext_grants`, `stall_cycles` output 32 each: performance counters (see Configuration).

## Operation

- FSM states: `S_CPU` (port to CPU), `S_EXT` (port to external, access performed), `S_ACK` (ack pulse, port back to CPU).
- `S_CPU`: port fields from CPU; `MemWrite = cpu_req & cpu_we`. Next state is `S_EXT` if `ext_req & (!cpu_req | scnt == MAX_STARVE)`, else `S_CPU`.
- Starvation counter `scnt`: increments in `S_CPU` when `ext_req & cpu_req` and the external side is not granted; saturates at `MAX_STARVE`; clears on entry to `S_EXT`.
- `S_EXT`: `DataAdr = ext_addr`, `WriteData = ext_wdata`, `Store = 3'b010`, `MemWrite = ext_we & (ext_addr[1:0] == 0)`. `cpu_stall = 1` unconditionally. `ext_rdata <= ReadData` and `ext_err <= (ext_addr[1:0] != 0)` at the end of the cycle. Next state is always `S_ACK`.
- Misaligned external access: no write, `ext_rdata` is still captured (don't-care), and `ext_err = 1` with the ack.
- `S_ACK`: `ext_ack = 1`, port to CPU, `cpu_stall = 0`; `ext_req` is ignored. Next state is always `S_CPU`. The external side drops `ext_req` or presents a new request in the following cycle.
- `cpu_stall` is 0 in `S_CPU` and `S_ACK`. CPU accesses never wait more than one cycle per external transaction.

## Timing

- Reset values: state `S_CPU`, `scnt = 0`, `ext_ack = 0`, `ext_err = 0`, `ext_rdata = 0`, `cpu_stall = 0`, counters 0. Port outputs follow the CPU inputs.
- Idle port: `ext_req` rises in cycle 0, the access happens in cycle 1 (`S_EXT`), and `ext_ack` is asserted in cycle 2. Latency is 2 cycles.
- Contended port: the external grant occurs at the latest after `MAX_STARVE` contended cycles, giving a worst-case ack in `MAX_STARVE + 2` cycles.
- Simultaneous `cpu_req` and `ext_req` with `scnt < MAX_STARVE`: the CPU wins.
- Reset asserted mid-transaction (in `S_EXT` or `S_ACK`): immediate return to `S_CPU`. No ack is produced and any write in progress is abandoned at the edge. The external side must reissue the request.
- `ext_ack`, `ext_err` and `ext_rdata` are registered. `cpu_stall` and the port mux are combinational from state.

## Configuration

- `DMEM_ARB_PERF_EN` defined:
  - `ext_grants` counts entries into `S_EXT`.
  - `stall_cycles` counts cycles with `cpu_stall = 1`.
  - Both are 32-bit, wrap at 2^32 and clear on reset.
- `DMEM_ARB_PERF_EN` undefined: both outputs are tied to 0 and no counter flops exist. The port list is unchanged.

## Structure

- Package `dmem_arb_pkg` holds:
  - state encodings `S_CPU = 2'd0`, `S_EXT = 2'd1`, `S_ACK = 2'd2`;
  - `STORE_WORD = 3'b010`;
  - `PERF_W = 32`.
- Sub-module `dmem_arb_perf` contains the two counters. It is instantiated only under `DMEM_ARB_PERF_EN`.

## Test plan

- **Idle external read.** Memory word 0x40 holds 0xDEADBEEF; `ext_req` with `ext_we = 0`, addr 0x40, `cpu_req = 0`. Required: `ext_ack` 2 cycles later with `ext_rdata = 0xDEADBEEF`, `ext_err = 0`, and `cpu_stall` high for exactly 1 cycle.
- **External write then CPU read.** External write of 0x12345678 to 0x80, then a CPU load from 0x80. Required: `Store = 3'b010` and `MemWrite = 1` during `S_EXT`; the CPU load returns 0x12345678.
- **Starvation.** `cpu_req` held high continuously with `MAX_STARVE = 4`. Required: the external side is granted on the 5th edge after `ext_req` rises, with `ext_ack` at cycle 6.
- **Misaligned.** External write to 0x41. Required: `MemWrite = 0` throughout, `ext_ack = 1` with `ext_err = 1`, and memory unchanged.
- **Reset mid-transaction.** Assert `reset` during `S_EXT`. Required: `cpu_stall = 0` and `ext_ack = 0` immediately; all outputs at reset values; normal service after `reset` deasserts.
- **Perf counters.** With `DMEM_ARB_PERF_EN` defined, run 3 external transactions. Required: `ext_grants = 3` and `stall_cycles = 3`. Without the macro, both read 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module : dmem_arb_pkg
// Brief  : Shared state encodings and constants for the data-memory arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    typedef enum logic [1:0] {
        S_CPU = 2'd0,
        S_EXT = 2'd1,
        S_ACK = 2'd2
    } state_t;

    localparam logic [2:0] STORE_WORD = 3'b010;
    localparam int         PERF_W     = 32;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module : dmem_arbiter_if
// Brief  : CPU, external-requester and data_mem signals of the memory arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface dmem_arbiter_if;
    import dmem_arb_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [2:0]        cpu_store;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_stall;

    logic              ext_req;
    logic              ext_we;
    logic [31:0]       ext_addr;
    logic [31:0]       ext_wdata;
    logic              ext_ack;
    logic              ext_err;
    logic [31:0]       ext_rdata;

    logic              MemWrite;
    logic [2:0]        Store;
    logic [31:0]       DataAdr;
    logic [31:0]       WriteData;
    logic [31:0]       ReadData;

    logic [PERF_W-1:0] ext_grants;
    logic [PERF_W-1:0] stall_cycles;

    // Environment side: CPU, external agent and memory
    modport master (
        output cpu_req, cpu_we, cpu_store, cpu_addr, cpu_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output ReadData,
        input  cpu_stall, ext_ack, ext_err, ext_rdata,
        input  MemWrite, Store, DataAdr, WriteData,
        input  ext_grants, stall_cycles
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_store, cpu_addr, cpu_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  ReadData,
        output cpu_stall, ext_ack, ext_err, ext_rdata,
        output MemWrite, Store, DataAdr, WriteData,
        output ext_grants, stall_cycles
    );

endinterface

`default_nettype wire

// File: rtl/dmem_arb_perf.sv
// ============================================================================
// Module : dmem_arb_perf
// Brief  : External-grant and CPU-stall cycle counters (DMEM_ARB_PERF_EN only).
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifdef DMEM_ARB_PERF_EN
module dmem_arb_perf
    import dmem_arb_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_grant,
    input  wire logic              i_stall,
    output logic      [PERF_W-1:0] o_ext_grants,
    output logic      [PERF_W-1:0] o_stall_cycles
);

    logic [PERF_W-1:0] r_grants;
    logic [PERF_W-1:0] r_stalls;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grants <= '0;
            r_stalls <= '0;
        end else begin
            if (i_grant) r_grants <= r_grants + PERF_W'(1);
            if (i_stall) r_stalls <= r_stalls + PERF_W'(1);
        end
    end

    assign o_ext_grants   = r_grants;
    assign o_stall_cycles = r_stalls;

endmodule
`endif

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module : dmem_arbiter
// Brief  : CPU-priority data-memory port arbiter with starvation guard.
//          Optional perf counters under macro DMEM_ARB_PERF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_STARVE = 4,
    parameter int SCNT_W     = 3
) (
    input  wire logic     clk,
    input  wire logic     reset,
    dmem_arbiter_if.slave bus
);

    localparam logic [SCNT_W-1:0] c_MAX_STARVE = SCNT_W'(MAX_STARVE);

    state_t            r_state;
    state_t            w_next;
    logic [SCNT_W-1:0] r_scnt;
    logic              r_ack;
    logic              r_err;
    logic [31:0]       r_rdata;

    logic              w_grant;
    logic              w_contend;
    logic              w_misalign;
    logic              w_stall;
    logic              w_we;
    logic [2:0]        w_store;
    logic [31:0]       w_adr;
    logic [31:0]       w_wdata;
    logic [PERF_W-1:0] w_ext_grants;
    logic [PERF_W-1:0] w_stall_cycles;

    assign w_contend  = bus.ext_req & bus.cpu_req;
    assign w_misalign = |bus.ext_addr[1:0];
    // CPU keeps the port unless it is idle or the external side has starved long enough
    assign w_grant    = (r_state == S_CPU) & bus.ext_req &
                        (~bus.cpu_req | (r_scnt == c_MAX_STARVE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_CPU;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_adr   = bus.cpu_addr;
        w_wdata = bus.cpu_wdata;
        w_store = bus.cpu_store;
        w_we    = bus.cpu_req & bus.cpu_we;
        case (r_state)
            S_CPU: begin
                if (w_grant) w_next = S_EXT;
            end
            S_EXT: begin
                w_adr   = bus.ext_addr;
                w_wdata = bus.ext_wdata;
                w_store = STORE_WORD;
                w_we    = bus.ext_we & ~w_misalign;
                w_stall = 1'b1;
                w_next  = S_ACK;
            end
            S_ACK: begin
                w_next = S_CPU;
            end
            default: begin
                w_next = S_CPU;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scnt <= '0;
        end else if (r_state == S_CPU) begin
            if (w_grant) begin
                r_scnt <= '0;
            end else if (w_contend && (r_scnt != c_MAX_STARVE)) begin
                r_scnt <= r_scnt + SCNT_W'(1);
            end
        end
    end

    // Read data and error are captured at the end of the access cycle and held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= (r_state == S_EXT);
            if (r_state == S_EXT) begin
                r_rdata <= bus.ReadData;
                r_err   <= w_misalign;
            end
        end
    end

`ifdef DMEM_ARB_PERF_EN
    dmem_arb_perf u_perf (
        .clk            (clk),
        .reset          (reset),
        .i_grant        (w_grant),
        .i_stall        (w_stall),
        .o_ext_grants   (w_ext_grants),
        .o_stall_cycles (w_stall_cycles)
    );
`else
    assign w_ext_grants   = '0;
    assign w_stall_cycles = '0;
`endif

    assign bus.cpu_stall    = w_stall;
    assign bus.ext_ack      = r_ack;
    assign bus.ext_err      = r_err;
    assign bus.ext_rdata    = r_rdata;
    assign bus.MemWrite     = w_we;
    assign bus.Store        = w_store;
    assign bus.DataAdr      = w_adr;
    assign bus.WriteData    = w_wdata;
    assign bus.ext_grants   = w_ext_grants;
    assign bus.stall_cycles = w_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module : tb_dmem_arbiter
// Brief  : Directed and randomized self-checking bench for dmem_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int MAX_STARVE = 4;

    logic clk;
    logic reset;
    logic mem_init;
    int   total;
    int   bad;
    int   m_grants;
    int   m_stalls;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.MAX_STARVE(MAX_STARVE), .SCNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int idx);
        if (idx == 16) return 32'hDEADBEEF;
        return 32'hA5A50000 | 32'(idx);
    endfunction

    // Data memory: combinational read, word write on the clock edge
    logic [31:0] mem [0:63];
    assign bus.ReadData = mem[bus.DataAdr[7:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= pat(i);
        end else if (bus.MemWrite) begin
            mem[bus.DataAdr[7:2]] <= bus.WriteData;
        end
    end

    function automatic logic [31:0] pexp(input int v);
`ifdef DMEM_ARB_PERF_EN
        return 32'(v);
`else
        return 32'(v & 0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_store = 3'b010;
        bus.cpu_addr  = 32'h0;
        bus.cpu_wdata = 32'h0;
        bus.ext_req   = 1'b0;
        bus.ext_we    = 1'b0;
        bus.ext_addr  = 32'h0;
        bus.ext_wdata = 32'h0;
    endtask

    // Uncontended external transaction: access next cycle, ack the one after
    task automatic txn(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                       input logic [31:0] exp_rd);
        tick();
        bus.cpu_req = 1'b0;
        bus.ext_req = 1'b1; bus.ext_we = we; bus.ext_addr = addr; bus.ext_wdata = wd;
        #1;
        chk("txn_req_stall", 32'(bus.cpu_stall), 32'd0);
        tick(); #1;
        chk("txn_acc_stall", 32'(bus.cpu_stall), 32'd1);
        m_grants++; m_stalls++;
        tick();
        bus.ext_req = 1'b0;
        #1;
        chk("txn_ack", 32'(bus.ext_ack), 32'd1);
        if (!we) chk("txn_rdata", bus.ext_rdata, exp_rd);
    endtask

    // Random-phase model state
    int          cyc, acc_cycle, ack_cycle, starve;
    logic        pend, in_acc, in_ack, ex_we, ex_al;
    logic [31:0] ex_rd;
    logic [31:0] shadow [0:63];

    initial begin
        total = 0; bad = 0; m_grants = 0; m_stalls = 0;
        idle_inputs();
        reset = 1'b1; mem_init = 1'b1;
        tick();
        mem_init = 1'b0;
        bus.cpu_addr = 32'h1C; bus.cpu_wdata = 32'h77;
        #1;
        chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_ack", 32'(bus.ext_ack), 32'd0);
        chk("rst_err", 32'(bus.ext_err), 32'd0);
        chk("rst_rdata", bus.ext_rdata, 32'd0);
        chk("rst_adr", bus.DataAdr, 32'h1C);
        chk("rst_wdata", bus.WriteData, 32'h77);
        chk("rst_grants", bus.ext_grants, 32'd0);
        chk("rst_stallcnt", bus.stall_cycles, 32'd0);
        tick();
        reset = 1'b0;
        idle_inputs();

        // Idle external read
        bus.ext_req = 1'b1; bus.ext_addr = 32'h40;
        #1;
        chk("t1_c0_stall", 32'(bus.cpu_stall), 32'd0);
        chk("t1_c0_ack", 32'(bus.ext_ack), 32'd0);
        tick(); #1;
        chk("t1_c1_stall", 32'(bus.cpu_stall), 32'd1);
        chk("t1_c1_adr", bus.DataAdr, 32'h40);
        chk("t1_c1_store", 32'(bus.Store), 32'd2);
        tick();
        bus.ext_req = 1'b0;
        #1;
        chk("t1_c2_ack", 32'(bus.ext_ack), 32'd1);
        chk("t1_c2_rdata", bus.ext_rdata, 32'hDEADBEEF);
        chk("t1_c2_err", 32'(bus.ext_err), 32'd0);
        chk("t1_c2_stall", 32'(bus.cpu_stall), 32'd0);
        tick(); #1;
        chk("t1_c3_ack", 32'(bus.ext_ack), 32'd0);

        // External write then CPU read
        bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 32'h80; bus.ext_wdata = 32'h12345678;
        tick(); #1;
        chk("t2_memwrite", 32'(bus.MemWrite), 32'd1);
        chk("t2_store", 32'(bus.Store), 32'd2);
        tick();
        idle_inputs();
        #1;
        chk("t2_ack", 32'(bus.ext_ack), 32'd1);
        tick();
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h80;
        #1;
        chk("t2_cpu_adr", bus.DataAdr, 32'h80);
        chk("t2_cpu_load", bus.ReadData, 32'h12345678);

        // Starvation with cpu_req held
        tick();
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10;
        bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 32'h44;
        for (int k = 0; k <= MAX_STARVE; k++) begin
            #1;
            chk($sformatf("t3_wait%0d_stall", k), 32'(bus.cpu_stall), 32'd0);
            chk($sformatf("t3_wait%0d_adr", k), bus.DataAdr, 32'h10);
            tick();
        end
        #1;
        chk("t3_grant_stall", 32'(bus.cpu_stall), 32'd1);
        chk("t3_grant_adr", bus.DataAdr, 32'h44);
        tick();
        bus.ext_req = 1'b0;
        #1;
        chk("t3_ack", 32'(bus.ext_ack), 32'd1);
        chk("t3_rdata", bus.ext_rdata, pat(17));
        chk("t3_ack_stall", 32'(bus.cpu_stall), 32'd0);

        // Misaligned external write
        tick();
        idle_inputs();
        bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 32'h41; bus.ext_wdata = 32'hCAFEF00D;
        #1;
        chk("t4_c0_memwrite", 32'(bus.MemWrite), 32'd0);
        tick(); #1;
        chk("t4_c1_memwrite", 32'(bus.MemWrite), 32'd0);
        chk("t4_c1_stall", 32'(bus.cpu_stall), 32'd1);
        tick();
        bus.ext_req = 1'b0;
        #1;
        chk("t4_ack", 32'(bus.ext_ack), 32'd1);
        chk("t4_err", 32'(bus.ext_err), 32'd1);
        chk("t4_c2_memwrite", 32'(bus.MemWrite), 32'd0);
        tick(); #1;
        chk("t4_mem_kept", mem[16], 32'hDEADBEEF);

        // Reset during the access cycle
        bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 32'h84; bus.ext_wdata = 32'h55;
        bus.cpu_addr = 32'h20;
        tick(); #1;
        chk("t5_acc_stall", 32'(bus.cpu_stall), 32'd1);
        chk("t5_acc_memwrite", 32'(bus.MemWrite), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("t5_rst_stall", 32'(bus.cpu_stall), 32'd0);
        chk("t5_rst_ack", 32'(bus.ext_ack), 32'd0);
        chk("t5_rst_err", 32'(bus.ext_err), 32'd0);
        chk("t5_rst_rdata", bus.ext_rdata, 32'd0);
        chk("t5_rst_memwrite", 32'(bus.MemWrite), 32'd0);
        chk("t5_rst_adr", bus.DataAdr, 32'h20);
        chk("t5_rst_grants", bus.ext_grants, 32'd0);
        chk("t5_rst_stallcnt", bus.stall_cycles, 32'd0);
        tick();
        idle_inputs();
        #1;
        chk("t5_ack_suppressed", 32'(bus.ext_ack), 32'd0);
        chk("t5_write_abandoned", mem[33], pat(33));
        tick();
        reset = 1'b0;
        m_grants = 0; m_stalls = 0;

        // Service after reset, and the perf counters
        txn(32'h40, 1'b0, 32'h0, 32'hDEADBEEF);
        txn(32'h8C, 1'b1, 32'h0BADF00D, 32'h0);
        txn(32'h8C, 1'b0, 32'h0, 32'h0BADF00D);
        tick(); #1;
        chk("t6_grants", bus.ext_grants, pexp(3));
        chk("t6_stallcnt", bus.stall_cycles, pexp(3));

        // Randomized traffic against a cycle-schedule model
        idle_inputs();
        mem_init = 1'b1;
        tick();
        mem_init = 1'b0;
        for (int i = 0; i < 64; i++) shadow[i] = pat(i);
        acc_cycle = -10; ack_cycle = -10; starve = 0; pend = 1'b0;
        ex_we = 1'b0; ex_al = 1'b1; ex_rd = 32'h0;
        for (cyc = 0; cyc < 500; cyc++) begin
            in_acc = (cyc == acc_cycle);
            in_ack = (cyc == ack_cycle);
            if (cyc == ack_cycle + 1) pend = 1'b0;
            if (!pend && $urandom_range(0, 3) == 0) begin
                pend = 1'b1;
                bus.ext_we    = 1'($urandom_range(0, 1));
                bus.ext_addr  = {24'h0, 6'($urandom_range(0, 63)),
                                 ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
                bus.ext_wdata = $urandom;
            end
            bus.ext_req   = pend;
            bus.cpu_req   = ($urandom_range(0, 9) < 7);
            bus.cpu_we    = ($urandom_range(0, 9) < 3);
            bus.cpu_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            bus.cpu_wdata = $urandom;
            #1;
            chk("rnd_stall", 32'(bus.cpu_stall), 32'(in_acc));
            chk("rnd_ack", 32'(bus.ext_ack), 32'(in_ack));
            if (in_acc) begin
                ex_we = bus.ext_we;
                ex_al = (bus.ext_addr[1:0] == 2'b00);
                ex_rd = shadow[bus.ext_addr[7:2]];
                chk("rnd_acc_adr", bus.DataAdr, bus.ext_addr);
                chk("rnd_acc_store", 32'(bus.Store), 32'd2);
                chk("rnd_acc_memwrite", 32'(bus.MemWrite), 32'(ex_we & ex_al));
                if (ex_we && ex_al) begin
                    chk("rnd_acc_wdata", bus.WriteData, bus.ext_wdata);
                    shadow[bus.ext_addr[7:2]] = bus.ext_wdata;
                end
                m_stalls++;
            end else begin
                chk("rnd_cpu_adr", bus.DataAdr, bus.cpu_addr);
                chk("rnd_cpu_memwrite", 32'(bus.MemWrite), 32'(bus.cpu_req & bus.cpu_we));
                if (bus.cpu_req && bus.cpu_we) begin
                    chk("rnd_cpu_wdata", bus.WriteData, bus.cpu_wdata);
                    shadow[bus.cpu_addr[7:2]] = bus.cpu_wdata;
                end else if (bus.cpu_req) begin
                    chk("rnd_cpu_load", bus.ReadData, shadow[bus.cpu_addr[7:2]]);
                end
            end
            if (in_ack) begin
                chk("rnd_ack_err", 32'(bus.ext_err), 32'(!ex_al));
                if (!ex_we && ex_al) chk("rnd_ack_rdata", bus.ext_rdata, ex_rd);
            end
            if (!in_acc && !in_ack && pend) begin
                if (!bus.cpu_req || starve == MAX_STARVE) begin
                    acc_cycle = cyc + 1;
                    ack_cycle = cyc + 2;
                    starve    = 0;
                    m_grants++;
                end else if (starve < MAX_STARVE) begin
                    starve++;
                end
            end
            tick();
        end
        #1;
        chk("rnd_grants", bus.ext_grants, pexp(m_grants));
        chk("rnd_stallcnt", bus.stall_cycles, pexp(m_stalls));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
